mem_bus_arbiter: RTL and testbench

//  Shares the single-port program/data memory of core_top between the core's instruction-fetch

---
 rtl/bus_pkg.sv | 8 +
 rtl/arb_pick.sv | 19 +
 rtl/mem_bus_arbiter.sv | 101 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared state/region types and constants for mem_bus_arbiter
package bus_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {REG_MEM, REG_LED, REG_NONE} region_t;
    localparam logic [31:0] LED_ADDR_DEFAULT = 32'hFFFF_0000;
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: 2-way winner select (fixed data priority, or round-robin under ARB_ROUND_ROBIN_EN)
module arb_pick
    import bus_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant
);
`ifdef ARB_ROUND_ROBIN_EN
    logic unused_if_req;
    assign unused_if_req = if_req;
    always_comb grant = !d_req ? PORT_IF : (if_req ? ~last_grant : PORT_D);
`else
    logic [1:0] unused_inputs;
    assign unused_inputs = {last_grant, if_req};
    always_comb grant = d_req ? PORT_D : PORT_IF;
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between fetch and data ports and decodes the LED register; define ARB_ROUND_ROBIN_EN for round-robin arbitration
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] LED_ADDR = ADDR_WIDTH'(LED_ADDR_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic                      if_ack,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic                      d_ack,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [7:0]                leds
);
    state_t state, next_state;
    region_t sel_region, lat_region;
    logic any_req, grant, sel_we, lat_port, lat_we, last_grant;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] resp_data, if_rdata_q, d_rdata_q;

    arb_pick u_arb_pick (
        .if_req(if_req),
        .d_req(d_req),
        .last_grant(last_grant),
        .grant(grant)
    );

    always_comb begin
        any_req = if_req || d_req;
        sel_addr = grant == PORT_D ? d_addr : if_addr;
        sel_we = grant == PORT_D && d_we;
        sel_region = sel_addr == LED_ADDR ? REG_LED :
                     (sel_addr >> (MEM_ADDR_WIDTH + 2)) == '0 ? REG_MEM : REG_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end

    always_comb
        next_state = state == IDLE ? (any_req ? ISSUE : IDLE) : (state == ISSUE ? RESP : IDLE);

    // Memory strobes are registered at the grant edge so they are high for exactly the ISSUE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_port <= PORT_IF;
            lat_we <= 1'b0;
            lat_region <= REG_NONE;
            last_grant <= PORT_D;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            leds <= 8'h00;
            if_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (state == IDLE && any_req) begin
            lat_port <= grant;
            lat_we <= sel_we;
            lat_region <= sel_region;
            last_grant <= grant;
            mem_en <= sel_region == REG_MEM;
            mem_we <= sel_region == REG_MEM && sel_we;
            mem_addr <= sel_addr[MEM_ADDR_WIDTH+1:2];
            mem_wdata <= d_wdata;
        end else if (state == ISSUE) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (lat_region == REG_LED && lat_we) leds <= mem_wdata[7:0];
        end else if (state == RESP) begin
            if (lat_port == PORT_D) d_rdata_q <= resp_data;
            else if_rdata_q <= resp_data;
        end
    end

    always_comb
        resp_data = lat_region == REG_MEM ? mem_rdata :
                    lat_region == REG_LED ? DATA_WIDTH'(leds) : '0;

    always_comb begin
        if_ack = state == RESP && lat_port == PORT_IF;
        d_ack = state == RESP && lat_port == PORT_D;
        if_rdata = if_ack ? resp_data : if_rdata_q;
        d_rdata = d_ack ? resp_data : d_rdata_q;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench with a behavioural memory/LED reference model
module tb_mem_bus_arbiter;
    localparam logic [31:0] LED_A = 32'hFFFF_0000;

    typedef struct {
        int kind;
        logic [31:0] data;
        bit is_mem;
    } exp_t;
    typedef struct {
        logic [9:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic [9:0] mem_addr;
    logic [7:0] leds;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic [7:0] ref_leds;
    exp_t ifq[$];
    exp_t dq[$];
    wr_t wq[$];
    int n_chk = 0;
    int n_pass = 0;
    int n_en = 0;
    int exp_en = 0;
    bit last_ack_d = 1'b1;
    logic [31:0] if_hold = '0;
    logic [31:0] d_hold = '0;
    bit d_hold_ok = 1'b1;

    mem_bus_arbiter dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ack(if_ack),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ack(d_ack),
        .d_rdata(d_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .leds(leds)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic if_txn(input logic [31:0] addr, output int lat);
        exp_t e;
        e.kind = 0;
        e.data = ref_mem[addr[11:2]];
        e.is_mem = 1'b1;
        ifq.push_back(e);
        if_req = 1'b1;
        if_addr = addr;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!if_ack && lat < 400);
        chk("if_ack_seen", 32'(if_ack), 32'd1);
        if_req = 1'b0;
    endtask

    task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output int lat);
        exp_t e;
        wr_t w;
        bit is_led;
        bit is_mem;
        is_led = addr == LED_A;
        is_mem = !is_led && addr < 32'h1000;
        e.is_mem = is_mem;
        if (we) begin
            e.kind = is_led ? 1 : 2;
            e.data = {24'b0, wdata[7:0]};
            if (is_led) ref_leds = wdata[7:0];
            if (is_mem) begin
                ref_mem[addr[11:2]] = wdata;
                w.a = addr[11:2];
                w.d = wdata;
                wq.push_back(w);
            end
        end else begin
            e.kind = 0;
            e.data = is_mem ? ref_mem[addr[11:2]] : (is_led ? {24'b0, ref_leds} : 32'h0);
        end
        dq.push_back(e);
        d_req = 1'b1;
        d_we = we;
        d_addr = addr;
        d_wdata = wdata;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!d_ack && lat < 400);
        chk("d_ack_seen", 32'(d_ack), 32'd1);
        d_req = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        wr_t w;
        if (rst_n) begin
            if (mem_en) n_en++;
            if (if_ack || d_ack) chk("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
            if (mem_we) begin
                chk("mem_we_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(w.a));
                    chk("mem_wdata", mem_wdata, w.d);
                end
            end
            if (if_ack) begin
                chk("if_ack_expected", 32'(ifq.size() != 0), 32'd1);
                if (ifq.size() != 0) begin
                    e = ifq.pop_front();
                    chk("if_rdata", if_rdata, e.data);
                    if_hold = e.data;
                    if (e.is_mem) exp_en++;
                end
                if (d_hold_ok && !d_ack) chk("d_rdata_hold", d_rdata, d_hold);
                last_ack_d = 1'b0;
            end
            if (d_ack) begin
                chk("d_ack_expected", 32'(dq.size() != 0), 32'd1);
                if (dq.size() != 0) begin
                    e = dq.pop_front();
                    if (e.is_mem) exp_en++;
                    if (e.kind == 0) begin
                        chk("d_rdata", d_rdata, e.data);
                        d_hold = e.data;
                        d_hold_ok = 1'b1;
                    end else begin
                        if (e.kind == 1) chk("leds", 32'(leds), e.data);
                        d_hold_ok = 1'b0;
                    end
                end
                if (!if_ack) chk("if_rdata_hold", if_rdata, if_hold);
                last_ack_d = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat_i, lat_d, en0;
        bit win_d;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1] = 32'h00A00093;
        ref_mem[1] = 32'h00A00093;
        ref_leds = 8'h00;
        if_req = 1'b0;
        if_addr = '0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        idle(3);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        rst_n = 1'b1;
        idle(2);

        if_txn(32'h4, lat);
        chk("fetch_latency", lat, 2);

        idle(1);
        en0 = n_en;
        d_txn(1'b1, LED_A, 32'h0000000F, lat);
        chk("led_wr_latency", lat, 2);
        idle(1);
        chk("led_wr_no_mem_en", n_en - en0, 0);
        chk("led_value", 32'(leds), 32'h0F);
        d_txn(1'b0, LED_A, 32'h0, lat);

        idle(1);
        d_txn(1'b1, 32'h10, 32'h12345678, lat);
        idle(1);
        d_txn(1'b0, 32'h10, 32'h0, lat);
        chk("mem_rd_latency", lat, 2);
        d_txn(1'b1, 32'hFFC, 32'hCAFEF00D, lat);
        d_txn(1'b0, 32'hFFC, 32'h0, lat);

        idle(1);
        en0 = n_en;
        d_txn(1'b0, 32'h8000_0000, 32'h0, lat);
        chk("unmapped_latency", lat, 2);
        d_txn(1'b0, 32'h1000, 32'h0, lat);
        d_txn(1'b1, 32'h1000, 32'hDEADBEEF, lat);
        idle(1);
        chk("unmapped_no_mem_en", n_en - en0, 0);

        idle(1);
`ifdef ARB_ROUND_ROBIN_EN
        win_d = !last_ack_d;
`else
        win_d = 1'b1;
`endif
        fork
            if_txn(32'h8, lat_i);
            d_txn(1'b0, 32'h100, 32'h0, lat_d);
        join
        chk("contend_first_lat", win_d ? lat_d : lat_i, 2);
        chk("contend_second_lat", win_d ? lat_i : lat_d, 5);

        idle(1);
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h104;
        idle(1);
        chk("abort_issue_mem_en", 32'(mem_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_d_ack", 32'(d_ack), 32'd0);
        chk("abort_d_rdata", d_rdata, 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);
        chk("abort_leds", 32'(leds), 32'd0);
        d_req = 1'b0;
        ref_leds = 8'h00;
        if_hold = '0;
        d_hold = '0;
        d_hold_ok = 1'b1;
        last_ack_d = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        d_txn(1'b0, 32'h104, 32'h0, lat);
        chk("post_reset_latency", lat, 2);

        fork
            begin
                int li;
                for (int i = 0; i < 40; i++) begin
                    idle($urandom_range(0, 3));
                    if_txn(32'($urandom_range(0, 63)) << 2, li);
                end
            end
            begin
                int ld;
                int r;
                for (int k = 0; k < 40; k++) begin
                    idle($urandom_range(0, 3));
                    r = $urandom_range(0, 5);
                    case (r)
                        0: d_txn(1'b0, 32'(64 + $urandom_range(0, 63)) << 2, 32'h0, ld);
                        1: d_txn(1'b1, 32'(64 + $urandom_range(0, 63)) << 2, $urandom, ld);
                        2: d_txn(1'b1, LED_A, $urandom, ld);
                        3: d_txn(1'b0, LED_A, 32'h0, ld);
                        4: d_txn(1'($urandom_range(0, 1)), 32'h8000_0000 + (32'($urandom_range(0, 1000)) << 2), $urandom, ld);
                        default: d_txn(1'($urandom_range(0, 1)), 32'hFFC, $urandom, ld);
                    endcase
                end
            end
        join

        idle(3);
        chk("mem_en_count", n_en, exp_en);
        chk("if_queue_drained", ifq.size(), 0);
        chk("d_queue_drained", dq.size(), 0);
        chk("wr_queue_drained", wq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
